// File: rtl/cache_miss_scheduler_pkg.sv
// ============================================================================
// cache_pkg
// Purpose : Shared definitions for the cache miss scheduler slice: the FSM
//           state encoding, the requester port IDs, counter widths and a
//           saturating-increment helper for the optional statistics block.
// Ports   : none (package)
// ============================================================================
package cache_pkg;

    // Scheduler FSM states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MEM_WAIT = 3'd2,
        FILL     = 3'd3,
        WRITE    = 3'd4,
        RESP     = 3'd5
    } state_t;

    // Requester port identifiers
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Width of the statistics counters
    localparam int STATS_WIDTH = 16;

    // Width of the main-memory latency down-counter (latency 1..15)
    localparam int LAT_CNT_WIDTH = 4;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [STATS_WIDTH-1:0] satInc(input logic [STATS_WIDTH-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/cache_miss_scheduler_if.sv
// ============================================================================
// cache_miss_scheduler_if
// Purpose : Requester-side bundle of the cache miss scheduler: the L1I miss
//           port, the L1D miss/write port, the per-port completion pulses
//           and the shared read-data bus.
// Signals : i_req/i_addr            L1I read request
//           d_req/d_we/d_addr/d_wdata L1D read or write request
//           i_ready/d_ready         one-cycle completion pulses
//           rdata                   data of the last completed read
// Modports: master = requesters (L1 caches), slave = scheduler
// ============================================================================
interface cache_miss_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  i_ready;
    logic                  d_ready;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  i_ready, d_ready, rdata
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output i_ready, d_ready, rdata
    );
endinterface

// File: rtl/cache_miss_scheduler_arb.sv
// ============================================================================
// rr_arbiter2
// Purpose : Two-way round-robin arbiter between the I and D requesters.
//           A sole requester always wins; on a tie the port that was not
//           granted last wins. The pointer only moves when a grant is taken.
// Ports   : clk, rst        clock, synchronous active-high reset
//           i_reqI, i_reqD  request lines
//           i_grantEn       scheduler is able to accept a grant this cycle
//           o_grantValid    at least one request present
//           o_grantPort     winning port (PORT_I / PORT_D)
// ============================================================================
module rr_arbiter2
    import cache_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_reqI,
    input  logic i_reqD,
    input  logic i_grantEn,
    output logic o_grantValid,
    output logic o_grantPort
);

    logic r_lastPort;
    logic w_pickD;

    // D wins when it is alone, or on a tie when I was granted last
    always_comb begin
        o_grantValid = i_reqI | i_reqD;
        w_pickD      = i_reqD & (~i_reqI | (r_lastPort == PORT_I));
        o_grantPort  = w_pickD ? PORT_D : PORT_I;
    end

    // Reset value PORT_D makes I the winner of the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lastPort <= PORT_D;
        end else if (i_grantEn && o_grantValid) begin
            r_lastPort <= o_grantPort;
        end
    end

endmodule

// File: rtl/cache_miss_scheduler.sv
// ============================================================================
// cache_miss_scheduler
// Purpose : Serialises L1I and L1D misses onto a shared L2 + main memory.
//           Reads probe L2 (one cycle); on a miss main memory is read for
//           MEM_LATENCY cycles and the line is filled into L2. D writes are
//           written through to L2 and main memory in the same cycle.
// Ports   : clk, rst                  clock, synchronous active-high reset
//           report                    statistics dump request
//           bus (slave)               requester handshake bundle
//           l2_hit, l2_rdata          L2 lookup result
//           l2_addr/l2_we/l2_wdata    L2 address and write port
//           mm_rdata                  main-memory read data
//           mm_addr/mm_we/mm_wdata    main-memory address and write port
//           busy                      transaction in progress
//           grant_d                   current owner is the D port
// Config  : CACHE_SCHED_STATS_EN adds saturating hit/miss/grant counters
//           and prints them on a rising edge of report.
// ============================================================================
module cache_miss_scheduler
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int MEM_LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    report,
    cache_miss_scheduler_if.slave   bus,
    input  logic                    l2_hit,
    input  logic [DATA_WIDTH-1:0]   l2_rdata,
    output logic [ADDR_WIDTH-1:0]   l2_addr,
    output logic                    l2_we,
    output logic [DATA_WIDTH-1:0]   l2_wdata,
    input  logic [DATA_WIDTH-1:0]   mm_rdata,
    output logic [ADDR_WIDTH-1:0]   mm_addr,
    output logic                    mm_we,
    output logic [DATA_WIDTH-1:0]   mm_wdata,
    output logic                    busy,
    output logic                    grant_d
);

    state_t                    r_state;
    state_t                    w_nextState;
    logic                      r_owner;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [LAT_CNT_WIDTH-1:0]  r_count;
    logic                      w_grantValid;
    logic                      w_grantPort;
    logic                      w_lastWait;

    rr_arbiter2 u_arb (
        .clk          (clk),
        .rst          (rst),
        .i_reqI       (bus.i_req),
        .i_reqD       (bus.d_req),
        .i_grantEn    (r_state == IDLE),
        .o_grantValid (w_grantValid),
        .o_grantPort  (w_grantPort)
    );

    assign w_lastWait = (r_count == LAT_CNT_WIDTH'(1));

    // State register plus the transaction context captured along the way
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= PORT_I;
            r_addr  <= '0;
            r_wdata <= '0;
            r_data  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (w_grantValid) begin
                        r_owner <= w_grantPort;
                        r_addr  <= (w_grantPort == PORT_D) ? bus.d_addr : bus.i_addr;
                        r_wdata <= bus.d_wdata;
                    end
                end
                LOOKUP: begin
                    if (l2_hit) begin
                        r_data <= l2_rdata;
                    end else begin
                        r_count <= LAT_CNT_WIDTH'(MEM_LATENCY);
                    end
                end
                MEM_WAIT: begin
                    r_count <= r_count - 1'b1;
                    if (w_lastWait) begin
                        r_data <= mm_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state decode; memory-side outputs are zero except in the
    // states that actually use them
    always_comb begin
        w_nextState = r_state;
        l2_addr     = '0;
        l2_we       = 1'b0;
        l2_wdata    = '0;
        mm_addr     = '0;
        mm_we       = 1'b0;
        mm_wdata    = '0;
        bus.i_ready = 1'b0;
        bus.d_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grantValid) begin
                    w_nextState = ((w_grantPort == PORT_D) && bus.d_we) ? WRITE : LOOKUP;
                end
            end
            LOOKUP: begin
                l2_addr     = r_addr;
                w_nextState = l2_hit ? RESP : MEM_WAIT;
            end
            MEM_WAIT: begin
                mm_addr = r_addr;
                if (w_lastWait) begin
                    w_nextState = FILL;
                end
            end
            FILL: begin
                l2_we       = 1'b1;
                l2_addr     = r_addr;
                l2_wdata    = r_data;
                w_nextState = RESP;
            end
            WRITE: begin
                l2_we       = 1'b1;
                mm_we       = 1'b1;
                l2_addr     = r_addr;
                mm_addr     = r_addr;
                l2_wdata    = r_wdata;
                mm_wdata    = r_wdata;
                w_nextState = RESP;
            end
            RESP: begin
                bus.i_ready = (r_owner == PORT_I);
                bus.d_ready = (r_owner == PORT_D);
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign bus.rdata = r_data;
    assign busy      = (r_state != IDLE);
    assign grant_d   = r_owner;

`ifdef CACHE_SCHED_STATS_EN
    logic [STATS_WIDTH-1:0] r_l2Hits;
    logic [STATS_WIDTH-1:0] r_l2Misses;
    logic [STATS_WIDTH-1:0] r_iGrants;
    logic [STATS_WIDTH-1:0] r_dGrants;
    logic                   r_reportQ;

    // Event counters; the dump fires once per rising edge of report
    always_ff @(posedge clk) begin
        if (rst) begin
            r_l2Hits   <= '0;
            r_l2Misses <= '0;
            r_iGrants  <= '0;
            r_dGrants  <= '0;
            r_reportQ  <= 1'b0;
        end else begin
            r_reportQ <= report;
            if (r_state == LOOKUP) begin
                if (l2_hit) r_l2Hits   <= satInc(r_l2Hits);
                else        r_l2Misses <= satInc(r_l2Misses);
            end
            if ((r_state == IDLE) && w_grantValid) begin
                if (w_grantPort == PORT_D) r_dGrants <= satInc(r_dGrants);
                else                       r_iGrants <= satInc(r_iGrants);
            end
            if (report && !r_reportQ) begin
                $display("cache_miss_scheduler stats: l2_hits=%0d l2_misses=%0d i_grants=%0d d_grants=%0d",
                         r_l2Hits, r_l2Misses, r_iGrants, r_dGrants);
            end
        end
    end
`else
    logic w_unusedReport;
    assign w_unusedReport = report;
`endif

endmodule
